// File: rtl/conv_pkg.sv
// rtl/conv_pkg.sv - bank codes, depths, FSM states and err bit indices for conv_mem_responder
package conv_pkg;
   localparam int DW         = 20;
   localparam int IMG_AW     = 12;
   localparam int IMG_DEPTH  = 1 << IMG_AW;
   localparam int L1_DEPTH   = 1024;
   localparam int L2_DEPTH   = 2048;
   localparam int WR_TOTAL_W = 14;

   localparam logic [2:0] NO_ACCESS        = 3'd0;
   localparam logic [2:0] L0_K0_MEM_ACCESS = 3'd1;
   localparam logic [2:0] L0_K1_MEM_ACCESS = 3'd2;
   localparam logic [2:0] L1_K0_MEM_ACCESS = 3'd3;
   localparam logic [2:0] L1_K1_MEM_ACCESS = 3'd4;
   localparam logic [2:0] L2_MEM_ACCESS    = 3'd5;

   typedef enum logic [1:0] {LOAD, ARM, RUN, DONE} state_t;

   localparam int ERR_CSEL  = 0;
   localparam int ERR_RANGE = 1;
   localparam int ERR_BOTH  = 2;
   localparam int ERR_STATE = 3;

   // Depth of the layer bank behind a csel code; 0 marks "no bank" (none or illegal).
   function automatic logic [IMG_AW:0] bank_depth(input logic [2:0] sel);
      case (sel)
         L0_K0_MEM_ACCESS, L0_K1_MEM_ACCESS: return IMG_DEPTH[IMG_AW:0];
         L1_K0_MEM_ACCESS, L1_K1_MEM_ACCESS: return L1_DEPTH[IMG_AW:0];
         L2_MEM_ACCESS:                      return L2_DEPTH[IMG_AW:0];
         default:                            return '0;
      endcase
   endfunction
endpackage

// File: rtl/conv_sp_ram.sv
// rtl/conv_sp_ram.sv - 1W/1R synchronous RAM, read-before-write, with a registered debug read port
module conv_sp_ram #(
   parameter int DEPTH = 4096,
   parameter int AW    = 12,
   parameter int WIDTH = 20
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             we,
   input  logic [AW-1:0]    waddr,
   input  logic [WIDTH-1:0] wdata,
   input  logic             re,
   input  logic [AW-1:0]    raddr,
   output logic [WIDTH-1:0] rdata,
   input  logic [AW-1:0]    dbg_addr,
   output logic [WIDTH-1:0] dbg_data
);
   logic [WIDTH-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (we) mem[waddr] <= wdata;
   end

   // Both read registers sample the array before this edge's write lands.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         rdata    <= '0;
         dbg_data <= '0;
      end else begin
         if (re) rdata <= mem[raddr];
         dbg_data <= mem[dbg_addr];
      end
   end
endmodule

// File: rtl/conv_mem_responder.sv
// rtl/conv_mem_responder.sv - image/layer memory responder with ready/busy start handshake
// Define CONV_MEM_PROTOCOL_CHECK_EN to build the sticky err flag logic.
module conv_mem_responder
   import conv_pkg::*;
(
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  ld_valid,
   input  logic [IMG_AW-1:0]     ld_addr,
   input  logic [DW-1:0]         ld_data,
   input  logic                  ld_last,
   output logic                  ld_done,
   output logic                  ready,
   input  logic                  busy,
   input  logic [IMG_AW-1:0]     iaddr,
   output logic [DW-1:0]         idata,
   input  logic                  cwr,
   input  logic [IMG_AW-1:0]     caddr_wr,
   input  logic [DW-1:0]         cdata_wr,
   input  logic                  crd,
   input  logic [IMG_AW-1:0]     caddr_rd,
   output logic [DW-1:0]         cdata_rd,
   input  logic [2:0]            csel,
   input  logic [2:0]            dbg_sel,
   input  logic [IMG_AW-1:0]     dbg_addr,
   output logic [DW-1:0]         dbg_data,
   output logic                  run_done,
   output logic [WR_TOTAL_W-1:0] wr_total,
   output logic [3:0]            err
);
   localparam int L1_AW = $clog2(L1_DEPTH);
   localparam int L2_AW = $clog2(L2_DEPTH);

   state_t          state;
   logic            in_run, img_we;
   logic [IMG_AW:0] sel_depth, dbg_depth;
   logic            wr_ok, rd_ok, dbg_ok, wr_acc, rd_acc;
   logic [5:1]      we, re;
   logic [DW-1:0]   rd_q  [6];
   logic [DW-1:0]   dbg_q [6];
   logic [2:0]      rd_sel_q, dbg_sel_q;
   logic            dbg_ok_q;

   assign in_run    = (state == RUN);
   assign img_we    = ld_valid && (state == LOAD);
   assign sel_depth = bank_depth(csel);
   assign wr_ok     = {1'b0, caddr_wr} < sel_depth;
   assign rd_ok     = {1'b0, caddr_rd} < sel_depth;
   assign wr_acc    = cwr && in_run && wr_ok;
   assign rd_acc    = crd && in_run;

   // The readback port maps code 0 onto the image, which has no layer code of its own.
   assign dbg_depth = (dbg_sel == NO_ACCESS) ? IMG_DEPTH[IMG_AW:0] : bank_depth(dbg_sel);
   assign dbg_ok    = {1'b0, dbg_addr} < dbg_depth;

   always_comb begin
      we = '0;
      re = '0;
      for (int b = 1; b < 6; b++) begin
         we[b] = wr_acc && (csel == 3'(b));
         re[b] = rd_acc && rd_ok && (csel == 3'(b));
      end
   end

   conv_sp_ram #(.DEPTH(IMG_DEPTH), .AW(IMG_AW), .WIDTH(DW)) u_image (
      .clk(clk), .reset(reset), .we(img_we), .waddr(ld_addr), .wdata(ld_data),
      .re(1'b1), .raddr(iaddr), .rdata(rd_q[0]), .dbg_addr(dbg_addr), .dbg_data(dbg_q[0]));
   conv_sp_ram #(.DEPTH(IMG_DEPTH), .AW(IMG_AW), .WIDTH(DW)) u_l0_k0 (
      .clk(clk), .reset(reset), .we(we[1]), .waddr(caddr_wr), .wdata(cdata_wr),
      .re(re[1]), .raddr(caddr_rd), .rdata(rd_q[1]), .dbg_addr(dbg_addr), .dbg_data(dbg_q[1]));
   conv_sp_ram #(.DEPTH(IMG_DEPTH), .AW(IMG_AW), .WIDTH(DW)) u_l0_k1 (
      .clk(clk), .reset(reset), .we(we[2]), .waddr(caddr_wr), .wdata(cdata_wr),
      .re(re[2]), .raddr(caddr_rd), .rdata(rd_q[2]), .dbg_addr(dbg_addr), .dbg_data(dbg_q[2]));
   conv_sp_ram #(.DEPTH(L1_DEPTH), .AW(L1_AW), .WIDTH(DW)) u_l1_k0 (
      .clk(clk), .reset(reset), .we(we[3]), .waddr(caddr_wr[L1_AW-1:0]), .wdata(cdata_wr),
      .re(re[3]), .raddr(caddr_rd[L1_AW-1:0]), .rdata(rd_q[3]),
      .dbg_addr(dbg_addr[L1_AW-1:0]), .dbg_data(dbg_q[3]));
   conv_sp_ram #(.DEPTH(L1_DEPTH), .AW(L1_AW), .WIDTH(DW)) u_l1_k1 (
      .clk(clk), .reset(reset), .we(we[4]), .waddr(caddr_wr[L1_AW-1:0]), .wdata(cdata_wr),
      .re(re[4]), .raddr(caddr_rd[L1_AW-1:0]), .rdata(rd_q[4]),
      .dbg_addr(dbg_addr[L1_AW-1:0]), .dbg_data(dbg_q[4]));
   conv_sp_ram #(.DEPTH(L2_DEPTH), .AW(L2_AW), .WIDTH(DW)) u_l2 (
      .clk(clk), .reset(reset), .we(we[5]), .waddr(caddr_wr[L2_AW-1:0]), .wdata(cdata_wr),
      .re(re[5]), .raddr(caddr_rd[L2_AW-1:0]), .rdata(rd_q[5]),
      .dbg_addr(dbg_addr[L2_AW-1:0]), .dbg_data(dbg_q[5]));

   assign idata = rd_q[0];

   // rd_sel_q only moves on a serviced read, so cdata_rd holds while crd is low.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         rd_sel_q  <= NO_ACCESS;
         dbg_sel_q <= NO_ACCESS;
         dbg_ok_q  <= 1'b0;
      end else begin
         if (rd_acc) rd_sel_q <= rd_ok ? csel : NO_ACCESS;
         dbg_sel_q <= dbg_sel;
         dbg_ok_q  <= dbg_ok;
      end
   end

   always_comb begin
      cdata_rd = '0;
      dbg_data = '0;
      for (int b = 1; b < 6; b++) begin
         if (rd_sel_q == 3'(b)) cdata_rd = rd_q[b];
      end
      for (int b = 0; b < 6; b++) begin
         if (dbg_ok_q && (dbg_sel_q == 3'(b))) dbg_data = dbg_q[b];
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state    <= LOAD;
         ready    <= 1'b0;
         ld_done  <= 1'b0;
         run_done <= 1'b0;
      end else begin
         case (state)
            LOAD: if (ld_valid && ld_last) begin
               state   <= ARM;
               ready   <= 1'b1;
               ld_done <= 1'b1;
            end
            ARM: if (busy) begin
               state <= RUN;
               ready <= 1'b0;
            end
            RUN: if (!busy) begin
               state    <= DONE;
               run_done <= 1'b1;
            end
            DONE: if (ld_valid) begin
               state    <= LOAD;
               run_done <= 1'b0;
               ld_done  <= 1'b0;
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset)                          wr_total <= '0;
      else if ((state == DONE) && ld_valid) wr_total <= '0;
      else if (wr_acc && (wr_total != '1))  wr_total <= wr_total + 1'b1;
   end

`ifdef CONV_MEM_PROTOCOL_CHECK_EN
   logic illegal_sel;
   assign illegal_sel = (csel > L2_MEM_ACCESS);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         err <= '0;
      end else begin
         if ((cwr || crd) && in_run && illegal_sel) err[ERR_CSEL] <= 1'b1;
         if (in_run && (sel_depth != '0) && ((cwr && !wr_ok) || (crd && !rd_ok)))
            err[ERR_RANGE] <= 1'b1;
         if (cwr && crd) err[ERR_BOTH] <= 1'b1;
         if ((cwr || crd) && !in_run) err[ERR_STATE] <= 1'b1;
      end
   end
`else
   assign err = 4'b0000;
`endif
endmodule

// File: tb/tb_conv_mem_responder.sv
// tb/tb_conv_mem_responder.sv - self-checking bench for conv_mem_responder
module tb_conv_mem_responder;
`ifdef CONV_MEM_PROTOCOL_CHECK_EN
   localparam bit CHK = 1'b1;
`else
   localparam bit CHK = 1'b0;
`endif

   logic        clk, reset;
   logic        ld_valid, ld_last, ld_done, ready, busy;
   logic [11:0] ld_addr, iaddr, caddr_wr, caddr_rd, dbg_addr;
   logic [19:0] ld_data, idata, cdata_wr, cdata_rd, dbg_data;
   logic        cwr, crd, run_done;
   logic [2:0]  csel, dbg_sel;
   logic [13:0] wr_total;
   logic [3:0]  err;

   conv_mem_responder dut (
      .clk(clk), .reset(reset), .ld_valid(ld_valid), .ld_addr(ld_addr), .ld_data(ld_data),
      .ld_last(ld_last), .ld_done(ld_done), .ready(ready), .busy(busy), .iaddr(iaddr),
      .idata(idata), .cwr(cwr), .caddr_wr(caddr_wr), .cdata_wr(cdata_wr), .crd(crd),
      .caddr_rd(caddr_rd), .cdata_rd(cdata_rd), .csel(csel), .dbg_sel(dbg_sel),
      .dbg_addr(dbg_addr), .dbg_data(dbg_data), .run_done(run_done), .wr_total(wr_total),
      .err(err));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Reference model: bank contents as plain arrays, rules applied in program order.
   logic [19:0] mm [1:5][0:4095];
   int          m_wr_total = 0;
   logic [3:0]  m_err = 4'h0;
   logic [19:0] m_cd = 20'h0;
   bit          m_run = 1'b0;

   function automatic int depth_of(input int sel);
      case (sel)
         1, 2:    return 4096;
         3, 4:    return 1024;
         5:       return 2048;
         default: return 0;
      endcase
   endfunction

   function automatic logic [19:0] model_dbg(input int sel, input int a);
      int d = depth_of(sel);
      if (d > 0 && a < d) return mm[sel][a];
      return 20'h0;
   endfunction

   task automatic model_cycle(input bit w, input bit r, input int sel, input int aw,
                              input int ar, input logic [19:0] wd);
      int d = depth_of(sel);
      if (w && r) m_err[2] = 1'b1;
      if (!m_run) begin
         if (w || r) m_err[3] = 1'b1;
         return;
      end
      if ((w || r) && sel > 5) m_err[0] = 1'b1;
      if (d > 0 && ((w && aw >= d) || (r && ar >= d))) m_err[1] = 1'b1;
      if (r) m_cd = (d > 0 && ar < d) ? mm[sel][ar] : 20'h0;
      if (w && d > 0 && aw < d) begin
         mm[sel][aw] = wd;
         if (m_wr_total < 16383) m_wr_total++;
      end
   endtask

   task automatic drive(input bit w, input bit r, input int sel, input int aw, input int ar,
                        input logic [19:0] wd, input int dsel, input int daddr);
      cwr = w; crd = r; csel = 3'(sel);
      caddr_wr = 12'(aw); caddr_rd = 12'(ar); cdata_wr = wd;
      dbg_sel = 3'(dsel); dbg_addr = 12'(daddr);
   endtask

   task automatic access(input bit w, input bit r, input int sel, input int aw, input int ar,
                         input logic [19:0] wd, input int dsel, input int daddr);
      logic [19:0] edbg;
      edbg = model_dbg(dsel, daddr);
      drive(w, r, sel, aw, ar, wd, dsel, daddr);
      model_cycle(w, r, sel, aw, ar, wd);
      tick();
      check("cdata_rd", 32'(cdata_rd), 32'(m_cd));
      check("wr_total", 32'(wr_total), 32'(m_wr_total));
      check("err", 32'(err), CHK ? 32'(m_err) : 32'h0);
      check("dbg_data", 32'(dbg_data), 32'(edbg));
      cwr = 1'b0; crd = 1'b0;
   endtask

   function automatic int pick_addr(input int sel);
      int d = depth_of(sel);
      int k = $urandom_range(0, 10);
      if (k < 8) return k;
      if (k == 8) return (d > 0) ? d - 1 : 4095;
      if (k == 9) return (d > 0 && d < 4096) ? d : 4095;
      return 4095;
   endfunction

   task automatic check_all_zero(input string tag);
      check({tag, "_ready"}, 32'(ready), 0);
      check({tag, "_ld_done"}, 32'(ld_done), 0);
      check({tag, "_run_done"}, 32'(run_done), 0);
      check({tag, "_idata"}, 32'(idata), 0);
      check({tag, "_cdata_rd"}, 32'(cdata_rd), 0);
      check({tag, "_dbg_data"}, 32'(dbg_data), 0);
      check({tag, "_wr_total"}, 32'(wr_total), 0);
      check({tag, "_err"}, 32'(err), 0);
   endtask

   typedef struct {
      bit w; bit r; int sel; int aw; int ar; logic [19:0] wd; int dsel; int daddr;
      logic [19:0] e_cd; int e_wrt; logic [3:0] e_err; logic [19:0] e_dbg;
   } vec_t;
   vec_t tbl [11];

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int r;
      //          w  r sel  aw    ar   wd         ds  da    e_cd       wrt err    e_dbg
      tbl[0]  = '{1, 0, 2, 4095, 0,    20'hF7295, 6, 0,    20'h0,     1,  4'h8, 20'h0};
      tbl[1]  = '{0, 1, 2, 0,    4095, 20'h0,     2, 4095, 20'hF7295, 1,  4'h8, 20'hF7295};
      tbl[2]  = '{1, 0, 3, 0,    0,    20'h11111, 2, 4095, 20'hF7295, 2,  4'h8, 20'hF7295};
      tbl[3]  = '{1, 0, 3, 1024, 0,    20'h22222, 2, 4095, 20'hF7295, 2,  4'hA, 20'hF7295};
      tbl[4]  = '{0, 1, 3, 0,    0,    20'h0,     2, 4095, 20'h11111, 2,  4'hA, 20'hF7295};
      tbl[5]  = '{0, 1, 5, 0,    2048, 20'h0,     2, 4095, 20'h0,     2,  4'hA, 20'hF7295};
      tbl[6]  = '{1, 0, 5, 7,    0,    20'h5,     2, 4095, 20'h0,     3,  4'hA, 20'hF7295};
      tbl[7]  = '{1, 1, 5, 7,    7,    20'h9,     2, 4095, 20'h5,     4,  4'hE, 20'hF7295};
      tbl[8]  = '{0, 1, 5, 0,    7,    20'h0,     2, 4095, 20'h9,     4,  4'hE, 20'hF7295};
      tbl[9]  = '{0, 0, 5, 0,    7,    20'h0,     5, 7,    20'h9,     4,  4'hE, 20'h9};
      tbl[10] = '{0, 1, 7, 0,    0,    20'h0,     3, 1024, 20'h0,     4,  4'hF, 20'h0};

      reset = 1'b0; busy = 1'b0; ld_valid = 1'b0; ld_last = 1'b0; ld_addr = '0; ld_data = '0;
      iaddr = '0; drive(0, 0, 0, 0, 0, 20'h0, 0, 0);
      tick(); tick();
      check_all_zero("reset");
      reset = 1'b1;

      for (int k = 0; k < 4096; k++) begin
         ld_valid = 1'b1; ld_addr = 12'(k); ld_data = 20'(k); ld_last = (k == 4095);
         tick();
         if (k == 4094) check("ld_done_early", 32'(ld_done), 0);
      end
      ld_valid = 1'b0; ld_last = 1'b0;
      check("ld_done", 32'(ld_done), 1);
      check("ready_arm", 32'(ready), 1);

      for (int i = 0; i < 5; i++) begin
         r = (i == 0) ? 4095 : $urandom_range(0, 4095);
         iaddr = 12'(r);
         if (i == 2) access(1, 0, 2, 4095, 0, 20'hABCDE, 6, 0);
         else tick();
         check("ready_hold", 32'(ready), 1);
         check("idata", 32'(idata), 32'(r));
      end

      busy = 1'b1;
      tick();
      m_run = 1'b1;
      check("ready_drop", 32'(ready), 0);
      check("run_done_run", 32'(run_done), 0);

      for (int i = 0; i < 11; i++) begin
         drive(tbl[i].w, tbl[i].r, tbl[i].sel, tbl[i].aw, tbl[i].ar, tbl[i].wd,
               tbl[i].dsel, tbl[i].daddr);
         model_cycle(tbl[i].w, tbl[i].r, tbl[i].sel, tbl[i].aw, tbl[i].ar, tbl[i].wd);
         tick();
         check($sformatf("tbl%0d_cdata_rd", i), 32'(cdata_rd), 32'(tbl[i].e_cd));
         check($sformatf("tbl%0d_wr_total", i), 32'(wr_total), 32'(tbl[i].e_wrt));
         check($sformatf("tbl%0d_err", i), 32'(err), CHK ? 32'(tbl[i].e_err) : 32'h0);
         check($sformatf("tbl%0d_dbg", i), 32'(dbg_data), 32'(tbl[i].e_dbg));
         cwr = 1'b0; crd = 1'b0;
      end

      for (int s = 1; s <= 5; s++) begin
         for (int a = 0; a < 9; a++) begin
            access(1, 0, s, (a < 8) ? a : depth_of(s) - 1, 0, 20'($urandom), 6, 0);
         end
      end

      for (int i = 0; i < 500; i++) begin
         int  sel  = $urandom_range(0, 7);
         int  dsel = $urandom_range(1, 7);
         bit  w    = ($urandom_range(0, 2) == 0);
         bit  rd   = ($urandom_range(0, 1) == 1);
         access(w, rd, sel, pick_addr(sel), pick_addr(sel), 20'($urandom), dsel, pick_addr(dsel));
      end

      for (int i = 0; i < 20000 && m_wr_total < 16383; i++) begin
         access(1, 0, 4, 1, 0, 20'($urandom), 4, 1);
      end
      for (int i = 0; i < 3; i++) access(1, 0, 4, 1, 0, 20'($urandom), 4, 1);
      check("wr_total_sat", 32'(wr_total), 32'd16383);
      access(0, 1, 4, 0, 1, 20'h0, 2, 4095);

      busy = 1'b0;
      tick();
      m_run = 1'b0;
      check("run_done", 32'(run_done), 1);
      check("ready_done", 32'(ready), 0);
      access(0, 1, 5, 0, 7, 20'h0, 2, 4095);
      access(0, 0, 0, 0, 0, 20'h0, 4, 1);

      ld_valid = 1'b1;
      tick();
      ld_valid = 1'b0;
      m_wr_total = 0;
      check("reload_run_done", 32'(run_done), 0);
      check("reload_ld_done", 32'(ld_done), 0);
      check("reload_wr_total", 32'(wr_total), 0);

      ld_valid = 1'b1; ld_last = 1'b1; ld_addr = '0; ld_data = '0;
      tick();
      ld_valid = 1'b0; ld_last = 1'b0;
      check("rearm_ready", 32'(ready), 1);
      busy = 1'b1;
      tick();
      m_run = 1'b1;
      access(1, 1, 5, 3, 7, 20'h12345, 5, 7);
      #3 reset = 1'b0;
      #1 check_all_zero("midrun_reset");
      tick();
      reset = 1'b1;
      busy = 1'b0;
      m_run = 1'b0; m_err = 4'h0; m_cd = 20'h0; m_wr_total = 0;
      tick();
      check("post_reset_ready", 32'(ready), 0);
      ld_valid = 1'b1; ld_last = 1'b1;
      tick();
      ld_valid = 1'b0; ld_last = 1'b0;
      check("post_reset_ld_done", 32'(ld_done), 1);
      check("post_reset_ready_arm", 32'(ready), 1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule

// File: doc/conv_mem_responder.md
# conv_mem_responder

Memory-side responder for the image convolution engine. It owns the 4096×20 image memory served on `iaddr`/`idata`, and the five layer memories (L0 K0/K1, L1 K0/K1, L2) accessed through `csel`/`cwr`/`crd`. It drives the `ready`/`busy` start handshake. It also gives the bench a preload port and a readback port, so the block serves as the synthesizable counterpart to the engine in integration and FPGA test builds.

## Interface
- `DW`, 20: pixel and layer data width.
- `IMG_AW`, 12: image and L0 address width (4096 words).
- `L1_DEPTH`, 1024: depth of each L1 bank.
- `L2_DEPTH`, 2048: depth of the L2 flatten bank.
- `clk`  in  1  rising-edge clock.
- `reset`  in  1  asynchronous, active-low reset.
- `ld_valid`  in  1  image preload write strobe.
- `ld_addr`  in  12  preload address.
- `ld_data`  in  20  preload pixel.
- `ld_last`  in  1  qualifies the final preload beat.
- `ld_done`  out  1  image loaded; handshake armed.
- `ready`  out  1  start request to the engine.
- `busy`  in  1  engine busy.
- `iaddr`  in  12  image read address.
- `idata`  out  20  image read data.
- `cwr`  in  1  layer write strobe.
- `caddr_wr`  in  12  layer write address.
- `cdata_wr`  in  20  layer write data.
- `crd`  in  1  layer read strobe.
- `caddr_rd`  in  12  layer read address.
- `cdata_rd`  out  20  layer read data.
- `csel`  in  3  bank select.
- `dbg_sel`  in  3  readback bank, same coding as `csel`.
- `dbg_addr`  in  12  readback address.
- `dbg_data`  out  20  readback data.
- `run_done`  out  1  engine finished (sticky).
- `wr_total`  out  14  count of accepted layer writes, saturating.
- `err`  out  4  sticky protocol error flags.

## Operation
- FSM states are LOAD, ARM, RUN and DONE; reset enters LOAD.
- LOAD:
  - `ld_valid` writes `ld_data` to `image[ld_addr]`.
  - `ld_valid & ld_last` moves the FSM to ARM and sets `ld_done`.
  - `iaddr` reads are still served in LOAD.
- ARM:
  - `ready`=1.
  - When `busy` is sampled 1, the FSM moves to RUN and `ready` drops on that same edge. `ready` is therefore high for at least 1 cycle.
- RUN:
  - Layer accesses are serviced.
  - When `busy` is sampled 0, the FSM moves to DONE and `run_done`=1.
- DONE:
  - Memories hold their contents.
  - `ld_valid` returns the FSM to LOAD, clears `run_done` and `ld_done`, and resets `wr_total`.
- `csel` bank coding:
  - 0: none.
  - 1/2: L0 K0/K1, 4096 deep.
  - 3/4: L1 K0/K1, `L1_DEPTH` deep.
  - 5: L2, `L2_DEPTH` deep.
  - 6/7: illegal.
- Writes: when `cwr` is high in RUN with a legal `csel` and an in-range address, the write is stored. Otherwise it is dropped.
- Reads: when `crd` is high in RUN, `cdata_rd` returns the bank word. An out-of-range address or illegal `csel` returns 0. With `crd`=0, `cdata_rd` holds its value.
- If `cwr` and `crd` are asserted together, both execute. The read returns the pre-write contents (read-before-write).
- `wr_total` increments by 1 per accepted write and saturates at 16383.
- `err` bits:
  - `[0]` access with illegal `csel`.
  - `[1]` out-of-range address.
  - `[2]` `cwr` and `crd` asserted together.
  - `[3]` `cwr` or `crd` asserted outside RUN.
- All `err` bits are sticky until reset.

## Timing
- Reset values: `ready`, `ld_done`, `run_done`, `idata`, `cdata_rd`, `dbg_data`, `wr_total` and `err` are all 0; the FSM is in LOAD. Memory contents are undefined.
- `idata`, `cdata_rd` and `dbg_data` are registered with one-cycle latency: an address presented at edge N produces data valid after edge N+1.
- Writes complete at the sampling edge. A read of the same address on the next cycle returns the new value.
- An asynchronous reset mid-RUN drops the FSM to LOAD and clears all flags; the bench must reload the image.
- The `dbg_*` readback port is independent of the FSM and usable in every state.

## Configuration
- `CONV_MEM_PROTOCOL_CHECK_EN` defined: the `err` detection logic is compiled in.
- Not defined: `err` is tied to 4'b0000 and no check logic is synthesized. Access behaviour (drop on illegal access, read returns 0) is identical in both builds.

## Structure
- `conv_pkg` holds:
  - the `csel` codes (`NO_ACCESS` .. `L2_MEM_ACCESS`);
  - bank depths and `DW`;
  - the FSM state enum;
  - the `err` bit indices.
- Sub-module `conv_sp_ram`: a parameterized synchronous RAM with 1 write port and 1 registered read port, read-before-write. It is instantiated 6 times (image, L0×2, L1×2, L2), each with an added debug read port.
- Top-level logic covers the FSM, bank decode and range check, output muxing, counters and error flags.

## Test plan
1. **Preload and serve:** preload `image[k]`=k for all 4096 words with `ld_last` on 4095 → `ld_done`=1, `ready`=1. Then `iaddr`=4095 → `idata`=4095 one cycle later.
2. **Start handshake:** in ARM, hold `busy`=0 for 5 cycles → `ready` stays 1. Raise `busy` → `ready`=0 at that edge, FSM in RUN. Drop `busy` → `run_done`=1.
3. **Layer write/read:** `csel`=2, write 20'hF7295 to address 4095, then read the same address → `cdata_rd`=20'hF7295. Readback via `dbg_sel`=2 matches. `wr_total`=1.
4. **Range checks:** `csel`=3, write address 1024 → write dropped, `err[1]`=1. `csel`=5, read address 2048 → `cdata_rd`=0.
5. **Simultaneous access:** `csel`=5, address 7 holds 5; write 9 and read address 7 in the same cycle → `cdata_rd`=5, `err[2]`=1. Next read of address 7 → 9.
6. **Reset and check disable:** assert `reset` mid-RUN → every output 0 and FSM in LOAD. With `CONV_MEM_PROTOCOL_CHECK_EN` undefined, rerun scenario 4 → `err`=0.
